audio_tone_gen: RTL and testbench

AUDIO_TONE_GEN -- requirements
Module: audio_tone_gen

---
 rtl/audio_tone_gen.sv | 146 ++++++++++++++
 tb/tb_audio_tone_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_tone_gen.sv
`default_nettype none
// ============================================================================
//  Module      : audio_tone_gen
//  Description : Square-wave tone generator with a selectable half-period and
//                PWM volume control. Pitch and volume changes are applied only
//                at phase and PWM-frame boundaries, so the output never glitches.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_tone_gen #(
    parameter int BASE_HALF = 1000,
    parameter int STEP_HALF = 50,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       audioEn,
    input  logic [3:0] audioSel,
    input  logic [4:0] audioVol,
    output logic       audio_out,
    output logic       tone_phase,
    output logic       active,
    output logic       edge_pulse
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam longint         c_cnt_max = (longint'(1) << CNT_W) - longint'(1);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);
    localparam logic [4:0]     c_pwm_top = 5'd31;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_sel_cur;
    logic [4:0]       r_vol_cur;
    logic [CNT_W-1:0] r_half_cnt;
    logic [4:0]       r_pwm_cnt;
    logic             r_tone_phase;
    logic             r_audio_out;
    logic             r_edge_pulse;
    logic             r_active;

    longint           w_diff;
    logic [CNT_W-1:0] w_hp;
    logic [CNT_W-1:0] w_hp_m1;
    logic             w_half_end;

    // Half-period for the selection in force; a zero or out-of-range result
    // (bad parameter choice) is clamped to one cycle.
    always_comb begin
        w_diff = longint'(BASE_HALF) - (longint'(r_sel_cur) * longint'(STEP_HALF));
        w_hp   = c_one;
        if ((w_diff > longint'(0)) && (w_diff <= c_cnt_max)) begin
            w_hp = w_diff[CNT_W-1:0];
        end
    end

    assign w_hp_m1    = w_hp - c_one;
    assign w_half_end = (r_half_cnt == w_hp_m1);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: the enable alone decides between IDLE and RUN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (audioEn)  w_state_next = S_RUN;
            S_RUN:   if (!audioEn) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Tone datapath: half-period counter, phase, PWM counter and output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel_cur    <= 4'd0;
            r_vol_cur    <= 5'd0;
            r_half_cnt   <= '0;
            r_pwm_cnt    <= 5'd0;
            r_tone_phase <= 1'b0;
            r_audio_out  <= 1'b0;
            r_edge_pulse <= 1'b0;
            r_active     <= 1'b0;
        end else begin
            r_active <= (w_state_next == S_RUN);
            case (r_state)
                S_IDLE: begin
                    r_audio_out  <= 1'b0;
                    r_edge_pulse <= 1'b0;
                    if (audioEn) begin
                        r_sel_cur    <= audioSel;
                        r_vol_cur    <= audioVol;
                        r_half_cnt   <= '0;
                        r_pwm_cnt    <= 5'd0;
                        r_tone_phase <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!audioEn) begin
                        // Leaving RUN wipes the tone so a restart begins clean.
                        r_half_cnt   <= '0;
                        r_pwm_cnt    <= 5'd0;
                        r_tone_phase <= 1'b0;
                        r_audio_out  <= 1'b0;
                        r_edge_pulse <= 1'b0;
                    end else begin
                        r_audio_out <= r_tone_phase & (r_pwm_cnt < r_vol_cur);
                        r_pwm_cnt   <= r_pwm_cnt + 5'd1;
                        if (r_pwm_cnt == c_pwm_top) begin
                            r_vol_cur <= audioVol;
                        end
                        if (w_half_end) begin
                            r_half_cnt   <= '0;
                            r_tone_phase <= ~r_tone_phase;
                            r_sel_cur    <= audioSel;
                            r_edge_pulse <= 1'b1;
                        end else begin
                            r_half_cnt   <= r_half_cnt + c_one;
                            r_edge_pulse <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_audio_out  <= 1'b0;
                    r_edge_pulse <= 1'b0;
                end
            endcase
        end
    end

    assign audio_out  = r_audio_out;
    assign tone_phase = r_tone_phase;
    assign active     = r_active;
    assign edge_pulse = r_edge_pulse;

endmodule
`default_nettype wire

// File: tb/tb_audio_tone_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_audio_tone_gen
//  Description : Self-checking bench for audio_tone_gen. A time-based model
//                predicts every output each cycle; directed tests pin phase
//                lengths and PWM duty with hand-computed numbers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_tone_gen;

    localparam int BASE_HALF = 1000;
    localparam int STEP_HALF = 50;
    localparam int CNT_W     = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       audioEn;
    logic [3:0] audioSel;
    logic [4:0] audioVol;
    logic       audio_out;
    logic       tone_phase;
    logic       active;
    logic       edge_pulse;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    audio_tone_gen #(
        .BASE_HALF (BASE_HALF),
        .STEP_HALF (STEP_HALF),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .audioEn    (audioEn),
        .audioSel   (audioSel),
        .audioVol   (audioVol),
        .audio_out  (audio_out),
        .tone_phase (tone_phase),
        .active     (active),
        .edge_pulse (edge_pulse)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Time is counted in edges since RUN entry; a phase ends at an absolute
    // edge number fixed when it starts, and the PWM position is k mod 32.
    bit m_run   = 1'b0;
    bit m_phase = 1'b0;
    bit m_out   = 1'b0;
    bit m_edge  = 1'b0;
    int m_k     = 0;
    int m_end   = 0;
    int m_vol   = 0;

    function automatic int hp_of(input int sel);
        int v;
        v = BASE_HALF - sel * STEP_HALF;
        if (v <= 0 || v >= (1 << CNT_W)) v = 1;
        return v;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_run = 1'b0; m_phase = 1'b0; m_out = 1'b0; m_edge = 1'b0;
                m_k = 0; m_end = 0; m_vol = 0;
            end else if (!m_run) begin
                m_out  = 1'b0;
                m_edge = 1'b0;
                if (audioEn) begin
                    m_run   = 1'b1;
                    m_phase = 1'b1;
                    m_k     = 0;
                    m_vol   = int'(audioVol);
                    m_end   = hp_of(int'(audioSel));
                end
            end else if (!audioEn) begin
                m_run = 1'b0; m_phase = 1'b0; m_out = 1'b0; m_edge = 1'b0;
            end else begin
                m_out = m_phase && ((m_k % 32) < m_vol);
                if ((m_k % 32) == 31) m_vol = int'(audioVol);
                m_k    = m_k + 1;
                m_edge = 1'b0;
                if (m_k == m_end) begin
                    m_phase = !m_phase;
                    m_end   = m_k + hp_of(int'(audioSel));
                    m_edge  = 1'b1;
                end
            end
        end
    end

    function automatic int outs();
        return int'({audio_out, tone_phase, active, edge_pulse});
    endfunction

    // Per-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cmp_en) begin
                checks = checks + 1;
                if (outs() != int'({m_out, m_phase, m_run, m_edge})) begin
                    errors = errors + 1;
                    $display("FAIL cycle_model t=%0t: got {out,phase,act,edge}=%b expected %b",
                             $time, 4'(outs()), {m_out, m_phase, m_run, m_edge});
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles until tone_phase changes and how many of them had
    // audio_out high; optionally changes audioSel after chg_at cycles.
    task automatic measure_phase(input int chg_at, input logic [3:0] chg_sel,
                                 output int len, output int hi);
        logic start;
        start = tone_phase;
        len   = 0;
        hi    = 0;
        while (1) begin
            if (len == chg_at) audioSel = chg_sel;
            tick();
            len = len + 1;
            if (audio_out) hi = hi + 1;
            if (tone_phase != start) break;
            if (len >= 5000) break;
        end
    endtask

    int len;
    int hi;

    initial begin
        rst = 1'b0; audioEn = 1'b0; audioSel = 4'd0; audioVol = 5'd0;
        repeat (3) tick();
        chk("reset_outputs", outs(), 0);
        rst = 1'b1;
        cmp_en = 1'b1;
        tick();
        chk("idle_after_release", outs(), 0);

        // sel 0, vol 31: 1000-cycle phases, 969 PWM-high cycles in the high phase
        audioEn = 1'b1; audioSel = 4'd0; audioVol = 5'd31;
        tick();
        chk("entry_phase", int'(tone_phase), 1);
        chk("entry_active", int'(active), 1);
        chk("entry_audio_out", int'(audio_out), 0);
        measure_phase(-1, 4'd0, len, hi);
        chk("sel0_high_len", len, 1000);
        chk("sel0_high_pwm", hi, 969);
        chk("sel0_edge_pulse", int'(edge_pulse), 1);
        measure_phase(-1, 4'd0, len, hi);
        chk("sel0_low_len", len, 1000);
        chk("sel0_low_pwm", hi, 0);

        // sel 15, vol 16: 250-cycle phases, 128 high cycles
        audioEn = 1'b0;
        tick();
        chk("disable_outputs", outs(), 0);
        audioSel = 4'd15; audioVol = 5'd16; audioEn = 1'b1;
        tick();
        measure_phase(-1, 4'd0, len, hi);
        chk("sel15_high_len", len, 250);
        chk("sel15_high_pwm", hi, 128);
        measure_phase(-1, 4'd0, len, hi);
        chk("sel15_low_len", len, 250);
        audioVol = 5'd4;
        repeat (100) tick();

        // pitch change mid-phase takes effect only at the next toggle
        audioEn = 1'b0;
        tick();
        audioSel = 4'd0; audioVol = 5'd31; audioEn = 1'b1;
        tick();
        measure_phase(400, 4'd15, len, hi);
        chk("selchg_cur_len", len, 1000);
        measure_phase(-1, 4'd0, len, hi);
        chk("selchg_next_len", len, 250);

        // zero volume: silent output, phase still toggles (sel 10 -> 500)
        audioEn = 1'b0;
        tick();
        audioSel = 4'd10; audioVol = 5'd0; audioEn = 1'b1;
        tick();
        measure_phase(-1, 4'd0, len, hi);
        chk("vol0_high_len", len, 500);
        chk("vol0_high_pwm", hi, 0);
        measure_phase(-1, 4'd0, len, hi);
        chk("vol0_low_len", len, 500);

        // drop enable mid-phase, then re-enable for a full fresh phase
        audioEn = 1'b0;
        tick();
        audioSel = 4'd15; audioVol = 5'd31; audioEn = 1'b1;
        tick();
        repeat (100) tick();
        audioEn = 1'b0;
        tick();
        chk("drop_outputs", outs(), 0);
        audioEn = 1'b1;
        tick();
        chk("reenable_phase", int'(tone_phase), 1);
        measure_phase(-1, 4'd0, len, hi);
        chk("reenable_len", len, 250);
        chk("reenable_pwm", hi, 243);

        // asynchronous reset pulse between edges during RUN
        repeat (50) tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 0);
        #1;
        rst = 1'b1;
        tick();
        chk("restart_phase", int'(tone_phase), 1);
        chk("restart_active", int'(active), 1);
        measure_phase(-1, 4'd0, len, hi);
        chk("restart_len", len, 250);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
